// File: rtl/adder_pkg.sv
// adder_pkg: shared constants for the bit-serial adder controller.
// Holds the FSM state encoding and the default operand width.
package adder_pkg;

  // Default operand / sum width used when the parent does not override WIDTH.
  localparam int DEFAULT_WIDTH = 8;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_fa_cell.sv
// serial_fa_cell: 1-bit full adder shared by the serial adder controller.
// It is built from two half adders whose carries are ORed together.
// The half adder below is the reusable 1-bit cell it is assembled from.

module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_sum,
  output logic o_carry
);

  assign o_sum   = i_a ^ i_b;
  assign o_carry = i_a & i_b;

endmodule

module serial_fa_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  logic w_partSum;
  logic w_partCarry;
  logic w_finalCarry;

  half_adder u_haFirst (
    .i_a     (i_a),
    .i_b     (i_b),
    .o_sum   (w_partSum),
    .o_carry (w_partCarry)
  );

  half_adder u_haSecond (
    .i_a     (w_partSum),
    .i_b     (i_cin),
    .o_sum   (o_sum),
    .o_carry (w_finalCarry)
  );

  // At most one of the two half-adder carries can be set, so OR is enough.
  assign o_cout = w_partCarry | w_finalCarry;

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder using one shared full-adder cell.
// Operands are latched on start, then summed LSB first, one bit per clock.
// The result is shifted into sum from the top, and done pulses for one cycle.
// Optional macro SERIAL_ADD_SUB_EN adds the sub port (sum = a - b, cout = no borrow).

module serial_add_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic             w_accept;
  logic             w_lastBit;
  logic             w_subSel;

  logic [WIDTH-1:0] r_aShift;
  logic [WIDTH-1:0] r_bShift;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_count;
  logic             r_carry;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic             w_cellSum;
  logic             w_cellCout;

`ifdef SERIAL_ADD_SUB_EN
  assign w_subSel = sub;
`else
  assign w_subSel = 1'b0;
`endif

  serial_fa_cell u_cell (
    .i_a    (r_aShift[0]),
    .i_b    (r_bShift[0]),
    .i_cin  (r_carry),
    .o_sum  (w_cellSum),
    .o_cout (w_cellCout)
  );

  // State register; reset parks the controller in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic plus the accept / last-bit strobes that steer the datapath.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_lastBit   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_nextState = ST_RUN;
          w_accept    = 1'b1;
        end
      end
      ST_RUN: begin
        if (r_count == LAST_BIT) begin
          w_nextState = ST_DONE;
          w_lastBit   = 1'b1;
        end
      end
      ST_DONE: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Registered status flags, derived from the upcoming state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_nextState != ST_IDLE);
      r_done <= (w_nextState == ST_DONE);
    end
  end

  // Datapath: load operands on accept, then shift one bit pair through the cell per RUN cycle.
  // Subtraction loads the ones' complement of b and seeds the carry with 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aShift <= '0;
      r_bShift <= '0;
      r_sum    <= '0;
      r_count  <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
    end else if (w_accept) begin
      r_aShift <= a;
      r_bShift <= b ^ {WIDTH{w_subSel}};
      r_count  <= '0;
      r_carry  <= w_subSel;
    end else if (r_state == ST_RUN) begin
      r_aShift <= r_aShift >> 1;
      r_bShift <= r_bShift >> 1;
      r_sum    <= {w_cellSum, r_sum[WIDTH-1:1]};
      r_carry  <= w_cellCout;
      r_count  <= r_count + 1'b1;
      if (w_lastBit) begin
        r_cout <= w_cellCout;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule
